// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI master round-robin scheduler.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } state_e;

  localparam int unsigned CMD_W = 16;
  localparam logic [CMD_W-1:0] ERR_DATA = 16'hDEAD;

endpackage

// File: rtl/spi_arb_rr_arbiter.sv
// Round-robin pick among NUM_REQ requesters; the search starts at the
// pointer and wraps. The pointer advances past the winner on load.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               load,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  // First active request at or after the pointer, modulo NUM_REQ
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant_idx = '0;
    any_req   = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr_q) + k) % NUM_REQ;
      if (!any_req && req[idx]) begin
        any_req   = 1'b1;
        grant_idx = IDX_W'(idx);
      end
    end
  end

  // Next pointer: one past the winner when a grant is taken
  always_comb begin
    ptr_d = ptr_q;
    if (load) ptr_d = IDX_W'((32'(grant_idx) + 1) % NUM_REQ);
  end

  // Pointer register
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/spi_arb.sv
// Shares one 16-bit SPI master among NUM_REQ requesters: grants one command
// at a time round-robin, strobes the master, routes slave-select, returns
// read data (or a timeout error) and enforces an idle gap between transfers.
module spi_arb
  import spi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 2000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [CMD_W*NUM_REQ-1:0] req_cmd,
  output logic [NUM_REQ-1:0]       ack,
  output logic [NUM_REQ-1:0]       resp_vld,
  output logic [CMD_W-1:0]         resp_data,
  output logic                     resp_err,
  output logic                     spi_wrt,
  output logic [CMD_W-1:0]         spi_cmd,
  input  logic                     spi_done,
  input  logic [CMD_W-1:0]         spi_rd_data,
  output logic [NUM_REQ-1:0]       ss_sel,
  output logic                     busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int unsigned TO_W  = 11;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [CMD_W-1:0]   spi_cmd_q, spi_cmd_d;
  logic [CMD_W-1:0]   resp_data_q, resp_data_d;
  logic [NUM_REQ-1:0] resp_vld_q, resp_vld_d;
  logic               resp_err_q, resp_err_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

  logic [IDX_W-1:0]   grant_idx;
  logic               any_req;
  logic               load;
  logic [NUM_REQ-1:0] win_oh;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .load      (load),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  // One-hot of the latched winner
  always_comb begin
    win_oh = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) win_oh[i] = (32'(win_q) == i);
  end

  // Next state, counters and response capture
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    spi_cmd_d   = spi_cmd_q;
    resp_data_d = resp_data_q;
    resp_vld_d  = '0;
    resp_err_d  = 1'b0;
    to_cnt_d    = to_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    load        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          load      = 1'b1;
          win_d     = grant_idx;
          spi_cmd_d = req_cmd[32'(grant_idx)*CMD_W +: CMD_W];
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        to_cnt_d = '0;
        state_d  = WAIT;
      end
      WAIT: begin
        to_cnt_d = to_cnt_q + 1'b1;
        // done has priority over the watchdog in the same cycle
        if (spi_done) begin
          resp_data_d = spi_rd_data;
          resp_vld_d  = win_oh;
          gap_cnt_d   = '0;
          state_d     = GAP;
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          resp_data_d = ERR_DATA;
          resp_err_d  = 1'b1;
          resp_vld_d  = win_oh;
          gap_cnt_d   = '0;
          state_d     = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) state_d = IDLE;
        else                                      gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      win_q       <= '0;
      spi_cmd_q   <= '0;
      resp_data_q <= '0;
      resp_vld_q  <= '0;
      resp_err_q  <= 1'b0;
      to_cnt_q    <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      spi_cmd_q   <= spi_cmd_d;
      resp_data_q <= resp_data_d;
      resp_vld_q  <= resp_vld_d;
      resp_err_q  <= resp_err_d;
      to_cnt_q    <= to_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  assign spi_wrt   = (state_q == ISSUE);
  assign ack       = (state_q == ISSUE) ? win_oh : '0;
  assign ss_sel    = (state_q != IDLE) ? win_oh : '0;
  assign busy      = (state_q != IDLE);
  assign spi_cmd   = spi_cmd_q;
  assign resp_data = resp_data_q;
  assign resp_vld  = resp_vld_q;
  assign resp_err  = resp_err_q;

endmodule

// File: tb/tb_spi_arb.sv
// Scoreboard bench for spi_arb: directed stimulus pushes expected grants and
// responses; monitors pop and compare when spi_wrt / resp_vld appear.
module tb_spi_arb;

  localparam int unsigned NREQ = 3;
  localparam int unsigned GAP  = 4;
  localparam int unsigned TMO  = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [47:0] req_cmd;
  logic [2:0]  ack, resp_vld, ss_sel;
  logic [15:0] resp_data, spi_cmd, spi_rd_data;
  logic        resp_err, spi_wrt, spi_done, busy;

  spi_arb #(.NUM_REQ(NREQ), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_cmd(req_cmd), .ack(ack),
    .resp_vld(resp_vld), .resp_data(resp_data), .resp_err(resp_err),
    .spi_wrt(spi_wrt), .spi_cmd(spi_cmd), .spi_done(spi_done),
    .spi_rd_data(spi_rd_data), .ss_sel(ss_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [2:0] oh; logic [15:0] cmd; } grant_t;
  typedef struct { logic [2:0] oh; logic [15:0] data; logic err; } resp_t;

  grant_t exp_g[$];
  resp_t  exp_r[$];
  grant_t mon_g;
  resp_t  mon_r;

  int errors = 0;
  int checks = 0;
  int unsigned last_vld_cyc = 0;
  bit have_last = 1'b0;

  // SPI slave model controls
  int unsigned mdl_delay = 0;
  logic [15:0] mdl_data = '0;
  bit mdl_echo = 1'b0;
  bit mdl_abort = 1'b0;
  logic [15:0] mdl_rd;
  bit mdl_ab;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h expected none", nm, act);
  endtask

  task automatic check_zero(input string p);
    check({p, "_ack"},       32'(ack),       32'h0);
    check({p, "_resp_vld"},  32'(resp_vld),  32'h0);
    check({p, "_resp_err"},  32'(resp_err),  32'h0);
    check({p, "_spi_wrt"},   32'(spi_wrt),   32'h0);
    check({p, "_ss_sel"},    32'(ss_sel),    32'h0);
    check({p, "_busy"},      32'(busy),      32'h0);
    check({p, "_resp_data"}, 32'(resp_data), 32'h0);
    check({p, "_spi_cmd"},   32'(spi_cmd),   32'h0);
  endtask

  task automatic wait_wrt(input string nm, output int unsigned at);
    int unsigned n = 0;
    at = 0;
    do begin @(negedge clk); n++; end while (spi_wrt !== 1'b1 && n < 5000);
    if (spi_wrt !== 1'b1) fail_now({nm, "_wrt_timeout"}, 32'h0);
    else at = cyc;
  endtask

  task automatic wait_vld(input string nm, output int unsigned at);
    int unsigned n = 0;
    at = 0;
    do begin @(negedge clk); n++; end while (resp_vld === 3'b000 && n < 5000);
    if (resp_vld === 3'b000) fail_now({nm, "_vld_timeout"}, 32'h0);
    else at = cyc;
  endtask

  task automatic wait_quiet(input string nm);
    int unsigned n = 0;
    do begin @(negedge clk); n++; end
    while ((exp_r.size() != 0 || exp_g.size() != 0 || busy !== 1'b0) && n < 5000);
    if (busy !== 1'b0 || exp_r.size() != 0) fail_now({nm, "_quiet_timeout"}, 32'(exp_r.size()));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_g.delete();
    exp_r.delete();
    have_last = 1'b0;
  endtask

  // SPI slave: answers each write strobe after mdl_delay clocks
  initial begin
    spi_done = 1'b0;
    spi_rd_data = '0;
    forever begin
      @(negedge clk);
      if (spi_wrt === 1'b1 && mdl_delay != 0) begin
        mdl_rd = mdl_echo ? ~spi_cmd : mdl_data;
        mdl_ab = 1'b0;
        for (int unsigned n = 0; n < mdl_delay; n++) begin
          @(negedge clk);
          if (mdl_abort) begin mdl_abort = 1'b0; mdl_ab = 1'b1; break; end
        end
        if (!mdl_ab) begin
          spi_done = 1'b1;
          spi_rd_data = mdl_rd;
          @(negedge clk);
          spi_done = 1'b0;
          spi_rd_data = '0;
        end
      end
    end
  end

  // Grant monitor
  always @(negedge clk) begin
    if (spi_wrt === 1'b1) begin
      if (exp_g.size() == 0) fail_now("unexpected_grant", 32'(ack));
      else begin
        mon_g = exp_g.pop_front();
        check("grant_ack", 32'(ack), 32'(mon_g.oh));
        check("grant_spi_cmd", 32'(spi_cmd), 32'(mon_g.cmd));
        check("grant_ss_sel", 32'(ss_sel), 32'(mon_g.oh));
      end
      if (have_last) check("idle_gap_ok", 32'((cyc - last_vld_cyc) >= GAP + 1), 32'h1);
    end else if (ack !== 3'b000) fail_now("ack_without_wrt", 32'(ack));
  end

  // Response monitor
  always @(negedge clk) begin
    if (resp_vld !== 3'b000) begin
      if (exp_r.size() == 0) fail_now("unexpected_resp_vld", 32'(resp_vld));
      else begin
        mon_r = exp_r.pop_front();
        check("resp_vld", 32'(resp_vld), 32'(mon_r.oh));
        check("resp_data", 32'(resp_data), 32'(mon_r.data));
        check("resp_err", 32'(resp_err), 32'(mon_r.err));
        check("resp_ss_sel", 32'(ss_sel), 32'(mon_r.oh));
      end
      last_vld_cyc = cyc;
      have_last = 1'b1;
    end else if (resp_err !== 1'b0) fail_now("err_without_vld", 32'(resp_err));
  end

  int unsigned t_i, t_v;

  initial begin
    rst = 1'b1;
    req = '0;
    req_cmd = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Single request from requester 1
    mdl_delay = 1080; mdl_data = 16'h1234; mdl_echo = 1'b0;
    exp_g.push_back('{3'b010, 16'hA5C3});
    exp_r.push_back('{3'b010, 16'h1234, 1'b0});
    @(negedge clk);
    req = 3'b010; req_cmd = {16'h0000, 16'hA5C3, 16'h0000};
    @(negedge clk);
    check("t1_latency_wrt", 32'(spi_wrt), 32'h1);
    check("t1_latency_ack", 32'(ack), 32'b010);
    t_i = cyc;
    req = '0;
    wait_vld("t1", t_v);
    check("t1_done_latency", 32'(t_v - t_i), 32'(1081));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t1_gap_ss_sel", 32'(ss_sel), 32'b010);
      check("t1_gap_busy", 32'(busy), 32'h1);
    end
    @(negedge clk);
    check("t1_idle_ss_sel", 32'(ss_sel), 32'h0);
    check("t1_idle_busy", 32'(busy), 32'h0);
    check("t1_data_hold", 32'(resp_data), 32'h1234);

    // All three requesting continuously from reset
    do_reset();
    mdl_delay = 10; mdl_echo = 1'b1;
    for (int r = 0; r < 2; r++) begin
      exp_g.push_back('{3'b001, 16'h1111}); exp_r.push_back('{3'b001, 16'hEEEE, 1'b0});
      exp_g.push_back('{3'b010, 16'h2222}); exp_r.push_back('{3'b010, 16'hDDDD, 1'b0});
      exp_g.push_back('{3'b100, 16'h4444}); exp_r.push_back('{3'b100, 16'hBBBB, 1'b0});
    end
    req = 3'b111; req_cmd = {16'h4444, 16'h2222, 16'h1111};
    for (int g = 0; g < 6; g++) wait_wrt("t2", t_i);
    req = '0;
    wait_quiet("t2");

    // Missing done: watchdog error, late done ignored
    mdl_delay = TMO + 50; mdl_data = 16'hCAFE; mdl_echo = 1'b0;
    exp_g.push_back('{3'b100, 16'h0303});
    exp_r.push_back('{3'b100, 16'hDEAD, 1'b1});
    req = 3'b100; req_cmd = {16'h0303, 16'h0000, 16'h0000};
    wait_wrt("t3", t_i);
    req = '0;
    wait_vld("t3", t_v);
    check("t3_timeout_latency", 32'(t_v - t_i), 32'(TMO + 1));
    repeat (70) @(negedge clk);
    check("t3_late_done_data", 32'(resp_data), 32'hDEAD);
    check("t3_late_done_busy", 32'(busy), 32'h0);
    mdl_delay = 20; mdl_echo = 1'b1;
    exp_g.push_back('{3'b010, 16'h5A5A});
    exp_r.push_back('{3'b010, 16'hA5A5, 1'b0});
    req = 3'b010; req_cmd = {16'h0000, 16'h5A5A, 16'h0000};
    wait_wrt("t3b", t_i);
    req = '0;
    wait_quiet("t3b");

    // Done coincident with the last watchdog cycle
    mdl_delay = TMO; mdl_data = 16'hBEEF; mdl_echo = 1'b0;
    exp_g.push_back('{3'b001, 16'h0F0F});
    exp_r.push_back('{3'b001, 16'hBEEF, 1'b0});
    req = 3'b001; req_cmd = {16'h0000, 16'h0000, 16'h0F0F};
    wait_wrt("t4", t_i);
    req = '0;
    wait_vld("t4", t_v);
    check("t4_coincident_latency", 32'(t_v - t_i), 32'(TMO + 1));
    wait_quiet("t4");

    // Reset during WAIT abandons the transfer
    mdl_delay = 100; mdl_echo = 1'b1;
    exp_g.push_back('{3'b001, 16'h1357});
    req = 3'b001; req_cmd = {16'h0000, 16'h0000, 16'h1357};
    wait_wrt("t5", t_i);
    req = '0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    mdl_abort = 1'b1;
    exp_r.delete();
    exp_g.delete();
    have_last = 1'b0;
    req = 3'b100; req_cmd = {16'h2468, 16'h0000, 16'h0000};
    exp_g.push_back('{3'b100, 16'h2468});
    exp_r.push_back('{3'b100, 16'hDB97, 1'b0});
    @(negedge clk);
    check_zero("t5_rst");
    rst = 1'b0;
    wait_wrt("t5b", t_i);
    req = '0;
    wait_quiet("t5b");

    // Requester 0 drops req during ISSUE: single completion, no regrant
    mdl_delay = 30; mdl_echo = 1'b1;
    exp_g.push_back('{3'b001, 16'h0A0B});
    exp_r.push_back('{3'b001, 16'hF5F4, 1'b0});
    @(negedge clk);
    req = 3'b001; req_cmd = {16'h0000, 16'h0000, 16'h0A0B};
    @(negedge clk);
    check("t6_issue_wrt", 32'(spi_wrt), 32'h1);
    req = '0;
    wait_quiet("t6");
    repeat (20) @(negedge clk);

    check("queues_empty", 32'(exp_g.size() + exp_r.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_arb.md
Name: spi_arb

Overview:
Round-robin scheduler that shares the single 16-bit SPI master between NUM_REQ on-chip requesters (e.g. inertial sensor, A2D, config).
- Accepts one command at a time.
- Pulses the master's write strobe, routes slave-select to the winning requester's slave, and returns the 16-bit read data with a per-requester valid pulse.
- A watchdog recovers from a missing done from the master.
- Enforces a minimum idle gap between transactions.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
GAP_CYCLES, 4, idle clk cycles after each transaction before the next grant (>=1)
TIMEOUT, 2000, max clk cycles in WAIT before an error response (< 2^11)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
req  input  NUM_REQ  per-requester request; held high with cmd until ack
req_cmd  input  16*NUM_REQ  requester i command at bits [16*i+15:16*i]
ack  output  NUM_REQ  one-cycle pulse, command of requester i accepted
resp_vld  output  NUM_REQ  one-cycle pulse, resp_data/resp_err valid for requester i
resp_data  output  16  read data of the last completed transaction
resp_err  output  1  qualifies resp_vld: 1 = timed out
spi_wrt  output  1  write strobe to SPI master, one-cycle pulse
spi_cmd  output  16  command to SPI master, registered
spi_done  input  1  done pulse from SPI master
spi_rd_data  input  16  read data from SPI master, valid with spi_done
ss_sel  output  NUM_REQ  one-hot slave-select routing; the SS_n of slave i = master SS_n | ~ss_sel[i]
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset, synchronous on rst at a clk edge; also applies mid-transaction, abandoning it with no resp_vld:
  - state=IDLE; rr pointer=0.
  - ack, resp_vld, resp_err, spi_wrt, ss_sel, busy = 0.
  - resp_data and spi_cmd = 16'h0000.
- All outputs are registered or decoded from state only. There is no combinational path from req or spi_done to any output.
- Arbitration:
  - Round-robin. The search starts at index ptr and wraps modulo NUM_REQ.
  - On a grant to index w: ptr <= (w+1) mod NUM_REQ.
  - After reset, index 0 has top priority.
- State machine:
  - IDLE: if any req bit is high, latch winner w and spi_cmd <= req_cmd[w], update ptr, and go to ISSUE. Otherwise stay.
  - ISSUE (exactly 1 cycle):
    - spi_wrt=1, ack[w]=1, ss_sel=onehot(w).
    - Clear the timeout counter, then go to WAIT.
    - Latency: req rising in IDLE at edge t gives ack/spi_wrt high during cycle t+1.
  - WAIT: ss_sel=onehot(w); the counter increments each cycle.
    - On spi_done: resp_data <= spi_rd_data, resp_err <= 0, resp_vld[w] pulses the next cycle, go to GAP.
    - Else if counter == TIMEOUT-1: resp_data <= 16'hDEAD, resp_err <= 1, resp_vld[w] pulses the next cycle, go to GAP.
    - spi_done in the same cycle as the timeout condition: spi_done wins (no error).
  - GAP:
    - ss_sel stays onehot(w), covering the master's SS_n rise after done.
    - Count GAP_CYCLES cycles, then go to IDLE with ss_sel=0.
    - spi_done arriving in GAP or IDLE (late, after a timeout) is ignored.
- resp_vld and resp_err are single-cycle pulses. resp_data holds until the next completion.
- A req that drops after the grant in IDLE does not cancel: the transaction completes and the response is still issued.
- A requester re-asserting req immediately after its ack is lower priority than the others at the next IDLE (round-robin).
- Widths:
  - Timeout counter: 11 bits, saturating not required because TIMEOUT < 2048.
  - Gap counter: $clog2(GAP_CYCLES+1) bits.
  - Winner index: $clog2(NUM_REQ) bits, minimum 1.

Decomposition:
- Package spi_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT, GAP} (2-bit)
  - CMD_W=16
  - ERR_DATA=16'hDEAD
- Sub-module rr_arbiter (NUM_REQ): req vector, ptr, and a load strobe in; grant index, any_req, and updated ptr out. The pointer register lives inside it with a synchronous active-high reset.

Test Plan:
- Single request: req=3'b010, cmd1=16'hA5C3; model returns 16'h1234 after 1080 cycles.
  -> ack[1] and spi_wrt at cycle t+1, spi_cmd=16'hA5C3, ss_sel=3'b010 through GAP, resp_vld=3'b010 with resp_data=16'h1234, resp_err=0.
- All three requesting continuously from reset.
  -> grants in order 0,1,2,0,1,2; each next spi_wrt is at least GAP_CYCLES+1 cycles after the previous resp_vld.
- Model never asserts spi_done.
  -> resp_vld[w] with resp_err=1 and resp_data=16'hDEAD exactly TIMEOUT cycles after entering WAIT.
  -> a late spi_done at +50 cycles is ignored; the next request is served normally.
- spi_done coincident with the final timeout cycle -> resp_err=0, resp_data=spi_rd_data.
- rst asserted mid-WAIT -> next cycle all outputs 0, busy=0; with req=3'b100 held, the next grant goes to index 2 (ptr=0 search) and no stale resp_vld appears.
- req[0] dropped during ISSUE -> transaction still completes, resp_vld[0] pulses once, and no second grant to 0 occurs.
